led_blink_bank: RTL and testbench



---
 rtl/led_blink_bank.sv | 156 +++++++++++++++
 tb/tb_led_blink_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_bank.sv
// led_blink_bank: bank of NCH independent LED/indicator channels.
// Each channel is OFF, ON, BLINK (toggle every `period` cycles) or
// ONESHOT (`period`-cycle pulse per trigger, retriggerable).
// Optional feature macro: LED_BANK_SYNC_EN adds a sync_pulse input that
// phase-aligns every channel currently in BLINK mode.
module led_blink_bank #(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 26,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [NCH-1:0]   trig,
`ifdef LED_BANK_SYNC_EN
  input  logic             sync_pulse,
`endif
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   busy
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic w_syncPulse;

`ifdef LED_BANK_SYNC_EN
  assign w_syncPulse = sync_pulse;
`else
  assign w_syncPulse = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mode_e            r_mode;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic             r_busy;

    mode_e            w_nextMode;
    logic [CNT_W-1:0] w_nextPeriod;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_nextLed;
    logic             w_nextBusy;
    logic             w_write;
    logic             w_terminal;

    // Channels outside 0..NCH-1 have no generate block, so out-of-range
    // writes simply match nothing.
    assign w_write    = cfg_we && (cfg_ch == CH_W'(i));
    assign w_terminal = (r_cnt == r_period);

    // Next-state: a config write wins over sync, which wins over normal mode
    // behaviour (including any trigger arriving in the same cycle).
    always_comb begin
      w_nextMode   = r_mode;
      w_nextPeriod = r_period;
      w_nextCnt    = r_cnt;
      w_nextLed    = r_led;
      w_nextBusy   = r_busy;
      if (w_write) begin
        w_nextMode   = mode_e'(cfg_mode);
        w_nextPeriod = cfg_period;
        w_nextCnt    = CNT_ONE;
        w_nextBusy   = 1'b0;
        w_nextLed    = (mode_e'(cfg_mode) == MODE_ON);
      end else if (w_syncPulse && (r_mode == MODE_BLINK)) begin
        w_nextCnt = CNT_ONE;
        w_nextLed = 1'b0;
      end else begin
        case (r_mode)
          MODE_OFF: begin
            w_nextCnt  = CNT_ONE;
            w_nextLed  = 1'b0;
            w_nextBusy = 1'b0;
          end
          MODE_ON: begin
            w_nextCnt  = CNT_ONE;
            w_nextLed  = 1'b1;
            w_nextBusy = 1'b0;
          end
          MODE_BLINK: begin
            w_nextBusy = 1'b0;
            if (r_period == CNT_ZERO) begin
              w_nextCnt = CNT_ONE;
              w_nextLed = 1'b0;
            end else if (w_terminal) begin
              w_nextCnt = CNT_ONE;
              w_nextLed = ~r_led;
            end else begin
              w_nextCnt = r_cnt + CNT_ONE;
            end
          end
          MODE_ONESHOT: begin
            if (r_period == CNT_ZERO) begin
              w_nextCnt  = CNT_ONE;
              w_nextLed  = 1'b0;
              w_nextBusy = 1'b0;
            end else if (trig[i]) begin
              w_nextCnt  = CNT_ONE;
              w_nextLed  = 1'b1;
              w_nextBusy = 1'b1;
            end else if (r_busy) begin
              if (w_terminal) begin
                w_nextCnt  = CNT_ONE;
                w_nextLed  = 1'b0;
                w_nextBusy = 1'b0;
              end else begin
                w_nextCnt = r_cnt + CNT_ONE;
              end
            end else begin
              w_nextCnt = CNT_ONE;
              w_nextLed = 1'b0;
            end
          end
          default: begin
            w_nextCnt  = CNT_ONE;
            w_nextLed  = 1'b0;
            w_nextBusy = 1'b0;
          end
        endcase
      end
    end

    // Channel state register; reset returns the channel to a clean OFF state.
    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        r_mode   <= MODE_OFF;
        r_period <= CNT_ZERO;
        r_cnt    <= CNT_ONE;
        r_led    <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_mode   <= w_nextMode;
        r_period <= w_nextPeriod;
        r_cnt    <= w_nextCnt;
        r_led    <= w_nextLed;
        r_busy   <= w_nextBusy;
      end
    end

    assign led[i]  = r_led;
    assign busy[i] = r_busy;
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// tb_led_blink_bank: directed, self-checking bench for led_blink_bank.
// Runs with NCH=6 so that out-of-range channel numbers are representable.
module tb_led_blink_bank;

  localparam int NCH   = 6;
  localparam int CNT_W = 8;
  localparam int CH_W  = 3;

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [NCH-1:0]   trig;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   busy;
`ifdef LED_BANK_SYNC_EN
  logic             sync_pulse;
`endif

  int checkCount;
  int passCount;

  led_blink_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .trig      (trig),
`ifdef LED_BANK_SYNC_EN
    .sync_pulse(sync_pulse),
`endif
    .led       (led),
    .busy      (busy)
  );

  // 10-unit clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // One-cycle config write; returns just after the write edge.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                               input logic [CNT_W-1:0] period);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = period;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    sys_rst_n  = 1'b0;
    cfg_we     = 1'b1;
    cfg_ch     = '0;
    cfg_mode   = M_ON;
    cfg_period = 8'd3;
    trig       = '1;
`ifdef LED_BANK_SYNC_EN
    sync_pulse = 1'b0;
`endif

    // Reset overrides a write and triggers
    for (int j = 0; j < 3; j++) begin
      tick();
      checkOutput("reset_led", 32'(led), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
    end
    sys_rst_n = 1'b1;
    cfg_we    = 1'b0;
    trig      = '0;
    for (int j = 0; j < 20; j++) begin
      tick();
      checkOutput("idle_led", 32'(led), 32'h0);
    end

    // BLINK period 3 on ch0: toggles at k+3, k+6, k+9
    applyStimulus(3'd0, M_BLINK, 8'd3);
    checkOutput("blink3_k0", 32'(led), 32'h0);
    for (int j = 1; j <= 9; j++) begin
      tick();
      checkOutput("blink3", 32'(led), 32'((j / 3) % 2));
    end
    applyStimulus(3'd0, M_OFF, 8'd0);
    checkOutput("ch0_off", 32'(led), 32'h0);

    // ONESHOT period 5 on ch1: 5-cycle pulse
    applyStimulus(3'd1, M_ONESHOT, 8'd5);
    checkOutput("os_armed_busy", 32'(busy), 32'h0);
    trig[1] = 1'b1;
    tick();
    trig[1] = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      checkOutput("os5_led", 32'(led), (j < 5) ? 32'h2 : 32'h0);
      checkOutput("os5_busy", 32'(busy), (j < 5) ? 32'h2 : 32'h0);
      tick();
    end

    // Retrigger at t+3 stretches the pulse to end at t+8
    trig[1] = 1'b1;
    tick();
    trig[1] = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      checkOutput("retrig_led", 32'(led), (j < 8) ? 32'h2 : 32'h0);
      checkOutput("retrig_busy", 32'(busy), (j < 8) ? 32'h2 : 32'h0);
      trig[1] = (j + 1 == 3);
      tick();
    end
    trig[1] = 1'b0;

    // BLINK period 1 toggles every cycle
    applyStimulus(3'd2, M_BLINK, 8'd1);
    for (int j = 0; j <= 5; j++) begin
      checkOutput("blink1", 32'(led[2]), 32'(j % 2));
      tick();
    end
    applyStimulus(3'd2, M_OFF, 8'd0);

    // BLINK period 0 is parked low
    applyStimulus(3'd3, M_BLINK, 8'd0);
    for (int j = 0; j < 5; j++) begin
      tick();
      checkOutput("blink0", 32'(led), 32'h0);
    end

    // ONESHOT period 0 ignores triggers
    applyStimulus(3'd4, M_ONESHOT, 8'd0);
    trig[4] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checkOutput("os0_busy", 32'(busy), 32'h0);
      checkOutput("os0_led", 32'(led), 32'h0);
    end
    trig[4] = 1'b0;

    // Out-of-range channel writes change nothing
    applyStimulus(3'd5, M_ON, 8'd0);
    checkOutput("ch5_on", 32'(led), 32'h20);
    applyStimulus(3'd6, M_ON, 8'd0);
    checkOutput("oor6", 32'(led), 32'h20);
    applyStimulus(3'd7, M_OFF, 8'd0);
    checkOutput("oor7", 32'(led), 32'h20);
    tick();
    checkOutput("oor_later", 32'(led), 32'h20);

    // cfg_we beats trig in the same cycle
    applyStimulus(3'd2, M_ONESHOT, 8'd4);
    trig[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    checkOutput("prio_pulse_busy", 32'(busy), 32'h4);
    trig[2] = 1'b1;
    applyStimulus(3'd2, M_ON, 8'd4);
    trig[2] = 1'b0;
    checkOutput("prio_on_led", 32'(led[2]), 32'h1);
    checkOutput("prio_on_busy", 32'(busy[2]), 32'h0);
    trig[2] = 1'b1;
    applyStimulus(3'd2, M_ONESHOT, 8'd4);
    trig[2] = 1'b0;
    checkOutput("prio_os_led", 32'(led[2]), 32'h0);
    checkOutput("prio_os_busy", 32'(busy[2]), 32'h0);

    // Reset mid-pulse aborts everything
    trig[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    tick();
    checkOutput("mid_busy", 32'(busy), 32'h4);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    checkOutput("midrst_led", 32'(led), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("postrst_led", 32'(led), 32'h0);

`ifdef LED_BANK_SYNC_EN
    // Two blinkers started 2 cycles apart are aligned by sync_pulse
    applyStimulus(3'd0, M_BLINK, 8'd4);
    tick();
    applyStimulus(3'd3, M_BLINK, 8'd4);
    tick();
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      checkOutput("sync", 32'(led), (j >= 4 && j < 8) ? 32'h9 : 32'h0);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
